// File: rtl/otn_tx_tran.sv
// otn_tx_tran: serial OTN frame transmitter with start pattern and 3-bit ARQ ack.
// Buffers one frame, streams it MSB first, retransmits on a bad or missing ack.
module otn_tx_tran #(
    parameter int FRAME_BYTES = 4158,
    parameter int ADDR_W      = 13,
    parameter int GAP_BITS    = 16,
    parameter int ACK_TIMEOUT = 8192,
    parameter int MAX_RETRIES = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_frame_data,
    input  logic       i_frame_data_valid,
    output logic       o_frame_data_ready,
    output logic       o_otn_tx_data,
    input  logic       i_otn_rx_ack,
    input  logic       i_arq_en,
    output logic       o_busy,
    output logic       o_ack_good,
    output logic       o_frame_dropped,
    output logic [3:0] o_retry_count
);

    localparam logic [47:0] PAT = 48'hF6F6F6282828;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_BITS + 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [TW-1:0]     TLAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0]     GLAST = GW'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SEND_PAT, SEND_DATA, WAIT_ACK, ACK_BIT, ACK_STOP, GAP
    } state_t;

    state_t            r_state;
    logic [7:0]        r_buf [0:FRAME_BYTES-1];
    logic [7:0]        r_rd;
    logic [7:0]        r_sh;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_byte;
    logic [5:0]        r_pcnt;
    logic [2:0]        r_bit;
    logic              r_end;
    logic              r_arq;
    logic              r_ackd;
    logic              r_idle_nxt;
    logic [TW-1:0]     r_timer;
    logic [GW-1:0]     r_gcnt;
    logic              r_s1;
    logic              r_s2;
    logic              r_tx;
    logic              r_good;
    logic              r_drop;
    logic [3:0]        r_retry;

    logic w_wr;
    logic w_timeout;
    logic w_resolve;
    logic w_good;

    assign w_wr      = (r_state == LOAD) && i_frame_data_valid;
    assign w_timeout = (r_state == WAIT_ACK) && r_s2 && (r_timer == TLAST);
    assign w_resolve = w_timeout || (r_state == ACK_STOP);
    assign w_good    = (r_state == ACK_STOP) && r_ackd && !r_s2;

    assign o_frame_data_ready = (r_state == LOAD);
    assign o_busy             = !((r_state == IDLE) || (r_state == LOAD));
    assign o_otn_tx_data      = r_tx;
    assign o_ack_good         = r_good;
    assign o_frame_dropped    = r_drop;
    assign o_retry_count      = r_retry;

    // Frame store with a registered read port used as the byte prefetch.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_buf[r_wcnt] <= i_frame_data;
        r_rd <= r_buf[r_raddr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_otn_rx_ack;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_good     <= 1'b0;
            r_drop     <= 1'b0;
            r_retry    <= 4'd0;
            r_wcnt     <= '0;
            r_raddr    <= '0;
            r_byte     <= '0;
            r_pcnt     <= 6'd0;
            r_bit      <= 3'd0;
            r_end      <= 1'b0;
            r_arq      <= 1'b0;
            r_ackd     <= 1'b0;
            r_idle_nxt <= 1'b1;
            r_timer    <= '0;
            r_gcnt     <= '0;
            r_sh       <= 8'd0;
        end else begin
            r_good <= 1'b0;
            r_drop <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_tx    <= 1'b1;
                    r_wcnt  <= '0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_wr) begin
                        r_wcnt <= r_wcnt + ADDR_W'(1);
                        if (r_wcnt == LAST) begin
                            r_state <= SEND_PAT;
                            r_tx    <= PAT[47];
                            r_pcnt  <= 6'd1;
                            r_raddr <= '0;
                        end
                    end
                end
                SEND_PAT: begin
                    r_tx   <= PAT[6'd47 - r_pcnt];
                    r_pcnt <= r_pcnt + 6'd1;
                    if (r_pcnt == 6'd47) begin
                        r_state <= SEND_DATA;
                        r_bit   <= 3'd0;
                        r_byte  <= '0;
                        r_end   <= 1'b0;
                    end
                end
                SEND_DATA: begin
                    if (r_end) begin
                        r_tx    <= 1'b1;
                        r_timer <= '0;
                        r_gcnt  <= '0;
                        if (r_arq) begin
                            r_state <= WAIT_ACK;
                        end else begin
                            r_state    <= GAP;
                            r_idle_nxt <= 1'b1;
                            r_retry    <= 4'd0;
                        end
                    end else begin
                        if (r_bit == 3'd0) begin
                            r_tx <= r_rd[7];
                            r_sh <= {r_rd[6:0], 1'b0};
                            if (r_raddr != LAST) r_raddr <= r_raddr + ADDR_W'(1);
                        end else begin
                            r_tx <= r_sh[7];
                            r_sh <= {r_sh[6:0], 1'b0};
                        end
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_byte == LAST) begin
                                r_end <= 1'b1;
                                r_arq <= i_arq_en;
                            end else begin
                                r_byte <= r_byte + ADDR_W'(1);
                            end
                        end
                    end
                end
                WAIT_ACK: begin
                    r_tx    <= 1'b1;
                    r_timer <= r_timer + TW'(1);
                    if (!r_s2) r_state <= ACK_BIT;
                end
                ACK_BIT: begin
                    r_ackd  <= r_s2;
                    r_state <= ACK_STOP;
                end
                ACK_STOP: begin
                    r_tx <= 1'b1;
                end
                GAP: begin
                    r_tx   <= 1'b1;
                    r_gcnt <= r_gcnt + GW'(1);
                    if (r_gcnt == GLAST) begin
                        if (r_idle_nxt) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= SEND_PAT;
                            r_tx    <= PAT[47];
                            r_pcnt  <= 6'd1;
                            r_raddr <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Ack verdict (good, bad or timed out) always passes through GAP.
            if (w_resolve) begin
                r_state <= GAP;
                r_gcnt  <= '0;
                r_tx    <= 1'b1;
                if (w_good) begin
                    r_good     <= 1'b1;
                    r_retry    <= 4'd0;
                    r_idle_nxt <= 1'b1;
                end else if (r_retry < 4'(MAX_RETRIES)) begin
                    r_retry    <= r_retry + 4'd1;
                    r_idle_nxt <= 1'b0;
                end else begin
                    r_drop     <= 1'b1;
                    r_retry    <= 4'd0;
                    r_idle_nxt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_otn_tx_tran.sv
// Bench for otn_tx_tran: random payloads and ack timing against a frame-level model.
// The line is recorded bit by bit and frames are located by their start pattern.
module tb_otn_tx_tran;

    localparam int FB = 4;
    localparam int AW = 2;
    localparam int GB = 4;
    localparam int AT = 64;
    localparam int MR = 2;
    localparam logic [47:0] PAT = 48'hF6F6F6282828;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_frame_data;
    logic       i_frame_data_valid;
    logic       o_frame_data_ready;
    logic       o_otn_tx_data;
    logic       i_otn_rx_ack;
    logic       i_arq_en;
    logic       o_busy;
    logic       o_ack_good;
    logic       o_frame_dropped;
    logic [3:0] o_retry_count;

    int   tot = 0;
    int   bad = 0;
    logic line_q[$];
    int   n_hs = 0;
    int   n_good = 0;
    int   n_drop = 0;
    int   n_rdy = 0;
    int   exp_retry = 0;

    always #5 clk = ~clk;

    otn_tx_tran #(
        .FRAME_BYTES(FB), .ADDR_W(AW), .GAP_BITS(GB),
        .ACK_TIMEOUT(AT), .MAX_RETRIES(MR)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_frame_data(i_frame_data),
        .i_frame_data_valid(i_frame_data_valid),
        .o_frame_data_ready(o_frame_data_ready),
        .o_otn_tx_data(o_otn_tx_data),
        .i_otn_rx_ack(i_otn_rx_ack),
        .i_arq_en(i_arq_en),
        .o_busy(o_busy),
        .o_ack_good(o_ack_good),
        .o_frame_dropped(o_frame_dropped),
        .o_retry_count(o_retry_count)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tot++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic hs;
        hs = o_frame_data_ready && i_frame_data_valid;
        @(posedge clk);
        #1;
        if (hs) n_hs++;
        line_q.push_back(o_otn_tx_data);
        if (o_ack_good) n_good++;
        if (o_frame_dropped) n_drop++;
        if (o_frame_data_ready) n_rdy++;
    endtask

    function automatic logic [79:0] bits(input int idx, input int len);
        logic [79:0] v = '0;
        for (int i = 0; i < len; i++) begin
            if (idx + i >= 0 && idx + i < line_q.size())
                v = {v[78:0], line_q[idx+i]};
            else
                v = {v[78:0], 1'bx};
        end
        return v;
    endfunction

    function automatic int zeros_from(input int idx);
        int z = 0;
        for (int i = idx; i < line_q.size(); i++)
            if (line_q[i] !== 1'b1) z++;
        return z;
    endfunction

    task automatic load(input logic [31:0] w, output int s);
        int k = 0;
        int n = 0;
        int h0;
        h0 = n_hs;
        s = -1;
        i_frame_data_valid = 1'b1;
        i_frame_data = w[31:24];
        while (k < FB && n < 100) begin
            step();
            n++;
            if (n_hs - h0 > k) begin
                k = n_hs - h0;
                if (k < FB) i_frame_data = w[31-8*k -: 8];
                else s = line_q.size() - 1;
            end
        end
        i_frame_data = 8'hFF;
        step();
        step();
        i_frame_data_valid = 1'b0;
        chk("handshakes", 80'(n_hs - h0), 80'(FB));
    endtask

    task automatic wait_frame(input int from, input logic [31:0] w, input string tag,
                              input bit gapchk, output int s);
        int z = -1;
        int p;
        int n = 0;
        p = from;
        while (z < 0 && n < 400) begin
            while (p < line_q.size() && z < 0) begin
                if (line_q[p] === 1'b0) z = p;
                p++;
            end
            if (z < 0) begin
                step();
                n++;
            end
        end
        chk({tag, "_seen"}, 80'(z >= 0), 80'd1);
        s = z - 4;
        if (z >= 0) begin
            while (line_q.size() < s + 84 && n < 600) begin
                step();
                n++;
            end
            chk(tag, bits(s, 80), {PAT, w});
            if (gapchk) chk({tag, "_gap"}, bits(s - GB, GB), 80'hF);
        end
    endtask

    task automatic send_ack(input int d, input logic [2:0] sym);
        repeat (d) step();
        for (int i = 2; i >= 0; i--) begin
            i_otn_rx_ack = sym[i];
            step();
        end
        i_otn_rx_ack = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [2:0]  sym;
        int s, f, f2, mark, g0, d0, r0, gl;

        rst_n = 1'b0;
        i_frame_data = 8'd0;
        i_frame_data_valid = 1'b0;
        i_otn_rx_ack = 1'b1;
        i_arq_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 80'({o_otn_tx_data, o_frame_data_ready, o_busy, o_ack_good,
                          o_frame_dropped, o_retry_count}), 80'(9'b1_0_0_0_0_0000));
        rst_n = 1'b1;

        // no ARQ, fixed payload, valid already high while idle
        mark = line_q.size();
        load(32'h01020304, s);
        wait_frame(mark, 32'h01020304, "t1_frame", 1'b0, f);
        chk("t1_start", 80'(f), 80'(s));
        repeat (GB + 4) step();
        chk("t1_gap", bits(f + 80, GB), 80'hF);
        chk("t1_idle", 80'({o_frame_data_ready, o_busy, o_retry_count}), 80'(6'b1_0_0000));

        // good ack 20 cycles after the frame
        i_arq_en = 1'b1;
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t2_frame", 1'b0, f);
        g0 = n_good;
        send_ack(16, 3'b010);
        repeat (20) step();
        chk("t2_good", 80'(n_good - g0), 80'd1);
        chk("t2_norexmit", 80'(zeros_from(f + 80)), 80'd0);
        chk("t2_idle", 80'({o_frame_data_ready, o_busy, o_retry_count}), 80'(6'b1_0_0000));

        // one bad ack, then good
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t3_frame", 1'b0, f);
        r0 = n_rdy;
        send_ack($urandom_range(2, 30), 3'b000);
        exp_retry = 1;
        wait_frame(f + 80, w, "t3_rexmit", 1'b1, f2);
        chk("t3_retry", 80'(o_retry_count), 80'(exp_retry));
        chk("t3_noready", 80'(n_rdy - r0), 80'd0);
        g0 = n_good;
        send_ack($urandom_range(2, 30), 3'b010);
        exp_retry = 0;
        repeat (20) step();
        chk("t3_good", 80'(n_good - g0), 80'd1);
        chk("t3_clr", 80'(o_retry_count), 80'(exp_retry));

        // bad acks until the frame is dropped
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t4_frame", 1'b0, f);
        d0 = n_drop;
        for (int r = 0; r <= MR; r++) begin
            sym = (r == 0) ? 3'b000 : ((r == 1) ? 3'b001 : 3'b011);
            send_ack($urandom_range(2, 30), sym);
            if (exp_retry < MR) begin
                exp_retry++;
                wait_frame(f + 80, w, "t4_rexmit", 1'b1, f);
                chk("t4_retry", 80'(o_retry_count), 80'(exp_retry));
            end else begin
                exp_retry = 0;
                repeat (20) step();
                chk("t4_drop", 80'(n_drop - d0), 80'd1);
                chk("t4_end", 80'({o_frame_data_ready, o_busy, o_retry_count}),
                    80'({1'b1, 1'b0, 4'(exp_retry)}));
                chk("t4_nomore", 80'(zeros_from(f + 80)), 80'd0);
            end
        end

        // timeout, then good ack on the retry
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t5_frame", 1'b0, f);
        wait_frame(f + 80, w, "t5_rexmit", 1'b1, f2);
        gl = f2 - (f + 80);
        chk("t5_tmo_len", 80'(gl >= AT && gl <= AT + GB + 8), 80'd1);
        exp_retry = 1;
        chk("t5_retry", 80'(o_retry_count), 80'(exp_retry));
        g0 = n_good;
        send_ack($urandom_range(2, 30), 3'b010);
        exp_retry = 0;
        repeat (20) step();
        chk("t5_good", 80'(n_good - g0), 80'd1);
        chk("t5_clr", 80'(o_retry_count), 80'(exp_retry));

        // stop bit 1 is a framing error even with data bit 1
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t5b_frame", 1'b0, f);
        g0 = n_good;
        send_ack($urandom_range(2, 30), 3'b011);
        exp_retry = 1;
        wait_frame(f + 80, w, "t5b_rexmit", 1'b1, f2);
        chk("t5b_retry", 80'(o_retry_count), 80'(exp_retry));
        chk("t5b_nogood", 80'(n_good - g0), 80'd0);
        send_ack($urandom_range(2, 30), 3'b010);
        exp_retry = 0;
        repeat (20) step();
        chk("t5b_clr", 80'(o_retry_count), 80'(exp_retry));

        // asynchronous reset at data bit 30 (a '0' bit)
        i_arq_en = 1'b0;
        w = $urandom & ~32'h2;
        mark = line_q.size();
        load(w, s);
        for (int n = 0; n < 200 && line_q.size() <= s + 78; n++) step();
        chk("t6_bit30", 80'(line_q[s+78]), 80'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 80'({o_otn_tx_data, o_busy}), 80'(2'b10));
        step();
        step();
        chk("t6_reset", 80'({o_otn_tx_data, o_frame_data_ready, o_busy, o_ack_good,
                             o_frame_dropped, o_retry_count}), 80'(9'b1_0_0_0_0_0000));
        rst_n = 1'b1;
        w = $urandom;
        mark = line_q.size();
        load(w, s);
        wait_frame(mark, w, "t6_fresh", 1'b0, f);
        chk("t6_start", 80'(f), 80'(s));
        repeat (GB + 4) step();
        chk("t6_idle", 80'({o_frame_data_ready, o_busy}), 80'(2'b10));

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
